// File: rtl/nios2_cpu_mult_pipe.sv
// nios2_cpu_mult_pipe: pipelined DATA_W x DATA_W multiplier built from four half-width partial products.
// Define NIOS2_MULT_HIGH_EN to build the high-word modes (MULXUU/MULXSU/MULXSS) and the hi*hi product.
module nios2_cpu_mult_pipe #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        mode,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              busy
);
    localparam int H   = DATA_W / 2;
    localparam int MID = (PIPE_STAGES > 2) ? PIPE_STAGES - 2 : 1;

    logic [1:0]               mode_eff;
    logic signed [H:0]        a_lo, b_lo, a_hi, b_hi;
    logic [DATA_W-1:0]        ll, ll_q;
    logic signed [DATA_W+1:0] lh, hl, hh;
    logic [DATA_W+1:0]        lh_q, hl_q, hh_q;
    logic                     v1;
    logic [1:0]               m1;
    logic [2*DATA_W-1:0]      fin_p;
    logic [1:0]               fin_m;
    logic                     fin_v, mid_busy;

    function automatic logic [2*DATA_W-1:0] combine(
        input logic [DATA_W-1:0] p_ll,
        input logic [DATA_W+1:0] p_lh,
        input logic [DATA_W+1:0] p_hl,
        input logic [DATA_W+1:0] p_hh
    );
        logic [2*DATA_W-1:0] x_lh, x_hl, x_hh;
        x_lh = {{(DATA_W-2){p_lh[DATA_W+1]}}, p_lh};
        x_hl = {{(DATA_W-2){p_hl[DATA_W+1]}}, p_hl};
        x_hh = {{(DATA_W-2){p_hh[DATA_W+1]}}, p_hh};
        return {{DATA_W{1'b0}}, p_ll} + (x_lh << H) + (x_hl << H) + (x_hh << DATA_W);
    endfunction

`ifdef NIOS2_MULT_HIGH_EN
    // hi halves gain one sign bit only for the operands the mode treats as signed
    assign mode_eff = mode;
    assign a_hi     = {mode[1] & src1[DATA_W-1], src1[DATA_W-1:H]};
    assign b_hi     = {mode[1] & mode[0] & src2[DATA_W-1], src2[DATA_W-1:H]};
    assign hh       = a_hi * b_hi;
`else
    assign mode_eff = mode & 2'b00;
    assign a_hi     = {1'b0, src1[DATA_W-1:H]};
    assign b_hi     = {1'b0, src2[DATA_W-1:H]};
    assign hh       = '0;
`endif

    assign a_lo = {1'b0, src1[H-1:0]};
    assign b_lo = {1'b0, src2[H-1:0]};
    assign ll   = src1[H-1:0] * src2[H-1:0];
    assign lh   = a_lo * b_hi;
    assign hl   = a_hi * b_lo;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            m1   <= '0;
            ll_q <= '0;
            lh_q <= '0;
            hl_q <= '0;
            hh_q <= '0;
        end else begin
            v1 <= flush ? 1'b0 : en ? in_valid : v1;
            if (en) begin
                m1   <= mode_eff;
                ll_q <= ll;
                lh_q <= lh;
                hl_q <= hl;
                hh_q <= hh;
            end
        end
    end

    generate
        if (PIPE_STAGES > 2) begin : g_mid
            logic [MID-1:0][2*DATA_W-1:0] p;
            logic [MID-1:0][1:0]          m;
            logic [MID-1:0]               v;
            logic [MID:0][2*DATA_W-1:0]   pn;
            logic [MID:0][1:0]            mn;
            logic [MID:0]                 vn;
            assign pn = {p, combine(ll_q, lh_q, hl_q, hh_q)};
            assign mn = {m, m1};
            assign vn = {v, v1};
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    p <= '0;
                    m <= '0;
                    v <= '0;
                end else begin
                    v <= flush ? '0 : en ? vn[MID-1:0] : v;
                    if (en) begin
                        p <= pn[MID-1:0];
                        m <= mn[MID-1:0];
                    end
                end
            end
            assign fin_p    = p[MID-1];
            assign fin_m    = m[MID-1];
            assign fin_v    = v[MID-1];
            assign mid_busy = |v;
        end else if (PIPE_STAGES == 2) begin : g_two
            assign fin_p    = combine(ll_q, lh_q, hl_q, hh_q);
            assign fin_m    = m1;
            assign fin_v    = v1;
            assign mid_busy = 1'b0;
        end else begin : g_one
            assign fin_p    = combine(ll, lh, hl, hh);
            assign fin_m    = mode_eff;
            assign fin_v    = in_valid;
            assign mid_busy = 1'b0;
        end
    endgenerate

    // result only moves when a live operation lands, so it holds between outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= flush ? 1'b0 : en ? fin_v : out_valid;
            if (en && fin_v && !flush)
                result <= (fin_m == 2'b00) ? fin_p[DATA_W-1:0] : fin_p[2*DATA_W-1:DATA_W];
        end
    end

    assign busy = out_valid | mid_busy | ((PIPE_STAGES > 1) && v1);

endmodule

// File: tb/tb_nios2_cpu_mult_pipe.sv
// tb_nios2_cpu_mult_pipe: random and directed checks of the multiplier against a queue-based product model.
module tb_nios2_cpu_mult_pipe;
    localparam int W = 32;
    localparam int P = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] src1 = '0;
    logic [W-1:0] src2 = '0;
    logic [1:0]   mode = '0;
    logic         out_valid, busy;
    logic [W-1:0] result;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [W-1:0] val;
        int           age;
    } op_t;
    op_t          fly[$];
    logic [W-1:0] exp_res = '0;
    logic         exp_vld = 1'b0;

    nios2_cpu_mult_pipe #(.DATA_W(W), .PIPE_STAGES(P)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
        .src1(src1), .src2(src2), .mode(mode),
        .out_valid(out_valid), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] m);
`ifdef NIOS2_MULT_HIGH_EN
        logic signed [W:0]     sa, sb;
        logic signed [2*W+1:0] p;
        sa = {m[1] & a[W-1], a};
        sb = {(m == 2'b11) & b[W-1], b};
        p  = sa * sb;
        return (m == 2'b00) ? p[W-1:0] : p[2*W-1:W];
`else
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return m[0] ? p[W-1:0] : p[W-1:0];
`endif
    endfunction

    // each op ages by one per enabled edge and emerges when its age reaches P
    task automatic model_edge();
        if (flush) begin
            fly.delete();
            exp_vld = 1'b0;
        end else if (en) begin
            foreach (fly[i]) fly[i].age++;
            if (in_valid) fly.push_back('{ref_mul(src1, src2, mode), 1});
            exp_vld = 1'b0;
            if (fly.size() != 0 && fly[0].age == P) begin
                exp_vld = 1'b1;
                exp_res = fly[0].val;
                void'(fly.pop_front());
            end
        end
    endtask

    task automatic cycle(input logic e, input logic f, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] m, input string tag);
        en = e;
        flush = f;
        in_valid = v;
        src1 = a;
        src2 = b;
        mode = m;
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_vld});
        check({tag, ".busy"}, {63'd0, busy}, {63'd0, (fly.size() != 0) || exp_vld});
        check({tag, ".result"}, {32'd0, result}, {32'd0, exp_res});
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return '1;
            1: return '0;
            2: return 32'h8000_0000;
            3: return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2;
        check("reset.out_valid", {63'd0, out_valid}, 64'd0);
        check("reset.busy", {63'd0, busy}, 64'd0);
        check("reset.result", {32'd0, result}, 64'd0);
        #10 reset_n = 1'b1;

        cycle(1, 0, 1, '1, '1, 2'b00, "b2b0");
        cycle(1, 0, 1, '1, '1, 2'b01, "b2b1");
`ifdef NIOS2_MULT_HIGH_EN
        check("b2b.mul", {32'd0, result}, 64'h1);
        cycle(1, 0, 1, '1, '1, 2'b11, "b2b2");
        check("b2b.mulxuu", {32'd0, result}, 64'hFFFF_FFFE);
        cycle(1, 0, 1, '1, 32'h2, 2'b10, "su0");
        check("b2b.mulxss", {32'd0, result}, 64'h0);
        cycle(1, 0, 1, '1, 32'h2, 2'b01, "su1");
        check("mulxsu", {32'd0, result}, 64'hFFFF_FFFF);
        cycle(1, 0, 0, '0, '0, 2'b00, "su2");
        check("mulxuu.same", {32'd0, result}, 64'h1);
`else
        check("b2b.low", {32'd0, result}, 64'h1);
        cycle(1, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 2'b11, "lo0");
        cycle(1, 0, 0, '0, '0, 2'b00, "lo1");
        check("low.only", {32'd0, result}, 64'h242D_2080);
`endif

        cycle(1, 0, 1, 32'h0001_0000, 32'h0001_0000, 2'b01, "stall0");
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, pick(), pick(), 2'b00, "stall");
        check("stall.no_out", {63'd0, out_valid}, 64'd0);
        cycle(1, 0, 0, '0, '0, 2'b00, "stall_out");
        check("stall.out_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, pick(), pick(), 2'b01, "stall_hold");

        cycle(1, 0, 1, 32'd3, 32'd5, 2'b00, "fl0");
        cycle(1, 0, 1, 32'd9, 32'd9, 2'b00, "fl1");
        cycle(1, 1, 1, 32'd4, 32'd4, 2'b00, "flush");
        check("flush.busy", {63'd0, busy}, 64'd0);
        cycle(1, 0, 0, '0, '0, 2'b00, "fl_idle");
        cycle(1, 0, 1, 32'd7, 32'd6, 2'b00, "fl_new");
        cycle(1, 0, 0, '0, '0, 2'b00, "fl_res");
        check("flush.7x6", {32'd0, result}, 64'h2A);

        cycle(1, 0, 1, 32'd11, 32'd13, 2'b00, "rst0");
        #2 reset_n = 1'b0;
        #1;
        check("midrst.out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst.busy", {63'd0, busy}, 64'd0);
        check("midrst.result", {32'd0, result}, 64'd0);
        fly.delete();
        exp_vld = 1'b0;
        exp_res = '0;
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, '0, '0, 2'b00, "post_rst");

        for (int i = 0; i < 500; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  pick(), pick(), 2'($urandom_range(0, 3)), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
